sd_spi_master: RTL and testbench

SD_SPI_MASTER -- requirements
Module: sd_spi_master

---
 rtl/sd_spi_pkg.sv | 25 ++
 rtl/sd_spi_clkgen.sv | 40 ++++
 rtl/sd_spi_master.sv | 153 +++++++++++++++
 tb/tb_sd_spi_master.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types, defaults and CRC helper for the SD-card SPI master.
// The CRC helper is only used when SD_SPI_CRC16_EN is defined.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_NEXT,
    S_FINISH
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DIV_W  = 8;
  localparam int DEF_LEN_W  = 10;

  // Sent when no transmit data is offered; all-ones keeps the card's DI line idle.
  localparam logic [63:0] FILL_WORD  = '1;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_spi_clkgen.sv
// SDCLK divider: low for div+1 cycles, high for div+1 cycles while enabled.
// Strobes fire in the last cycle of each phase, i.e. on the cycle before SDCLK toggles.
module sd_spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             sclk_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [DIV_W-1:0] cnt_q;
  logic             sclk_q;
  logic             wrap;

  assign wrap = en_i && (cnt_q == div_i);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (wrap) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = wrap && !sclk_q;
  assign fall_o = wrap && sclk_q;

endmodule

// File: rtl/sd_spi_master.sv
// SPI-mode (mode 0) burst master for SD cards with optional transmit CRC16.
// Define SD_SPI_CRC16_EN to build the CRC16-CCITT generator; otherwise crc_out is 0.
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  nwords,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              keep_cs,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       crc_out,
  output logic              SDCS,
  output logic              SDCLK,
  output logic              SDDO,
  input  logic              SDDI
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_e            state_q;
  logic [LEN_W-1:0]  nwords_q;
  logic [LEN_W-1:0]  word_cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic              keep_cs_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              cs_q;

  logic sclk, rise, fall;

  sd_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk    (clk),
    .n_rst  (n_rst),
    .en_i   (state_q == S_SHIFT),
    .div_i  (div_q),
    .sclk_o (sclk),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      nwords_q   <= '0;
      word_cnt_q <= '0;
      div_q      <= '0;
      keep_cs_q  <= 1'b0;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '1;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b1;
    end else begin
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      if (rise) rx_sr_q <= {rx_sr_q[DATA_W-2:0], SDDI};
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LOAD;
            busy_q     <= 1'b1;
            cs_q       <= 1'b0;
            nwords_q   <= nwords;
            div_q      <= clk_div;
            keep_cs_q  <= keep_cs;
            word_cnt_q <= '0;
          end
        end
        S_LOAD: begin
          tx_sr_q   <= tx_valid ? tx_data : FILL_WORD[DATA_W-1:0];
          bit_cnt_q <= '0;
          state_q   <= S_SHIFT;
        end
        S_SHIFT: begin
          // Ones shift in behind the data so SDDO idles high between words.
          if (fall) begin
            tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b1};
            if (bit_cnt_q == LAST_BIT) begin
              state_q    <= S_NEXT;
              rx_data_q  <= rx_sr_q;
              rx_valid_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        S_NEXT: begin
          if (word_cnt_q == nwords_q) begin
            state_q <= S_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cs_q    <= ~keep_cs_q;
          end else begin
            word_cnt_q <= word_cnt_q + 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SD_SPI_CRC16_EN
  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (state_q == S_IDLE && start) crc_d = '0;
    else if (rise)                  crc_d = crc16_step(crc_q, tx_sr_q[DATA_W-1]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc_out = crc_q;
`else
  assign crc_out = '0;
`endif

  assign tx_ready = (state_q == S_LOAD) && tx_valid;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign SDCS     = cs_q;
  assign SDCLK    = sclk;
  assign SDDO     = tx_sr_q[DATA_W-1];

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed self-checking bench for sd_spi_master (8-bit words, 8-bit divider, 10-bit length).
module tb_sd_spi_master;

`ifdef SD_SPI_CRC16_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic [9:0] nwords;
  logic [7:0] clk_div;
  logic       keep_cs;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic [15:0] crc_out;
  logic       SDCS, SDCLK, SDDO, SDDI;

  sd_spi_master dut (
    .clk(clk), .n_rst(n_rst), .start(start), .nwords(nwords), .clk_div(clk_div),
    .keep_cs(keep_cs), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .crc_out(crc_out),
    .SDCS(SDCS), .SDCLK(SDCLK), .SDDO(SDDO), .SDDI(SDDI)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] tx_bytes[$];
  logic [7:0] rx_bytes[$];
  int  rise_cnt, n_txr, done_iter, rxv_iter, bad_high, bad_low;
  bit  done_seen;
  logic cs_done, busy_done, sclk_done, first_busy, first_cs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] crc_ref(input logic [7:0] b, input int n);
    logic [15:0] c;
    logic fb;
    c = 16'h0000;
    for (int k = 0; k < n; k++)
      for (int i = 7; i >= 0; i--) begin
        fb = c[15] ^ b[i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  function automatic int burst_cycles(input int nw, input int div);
    return (nw + 1) * (2 + 16 * (div + 1));
  endfunction

  // Runs one burst to done, recording serialised bytes, received words and SDCLK phase lengths.
  task automatic burst(input int nw, input int div, input bit keep, input bit valid,
                       input logic [7:0] word, input logic [7:0] rx_pat, input bit extra);
    logic prev;
    logic [7:0] acc;
    int low_run, high_run, exp_low, limit;
    tx_bytes.delete(); rx_bytes.delete();
    rise_cnt = 0; n_txr = 0; done_iter = -1; rxv_iter = -1; bad_high = 0; bad_low = 0;
    done_seen = 0; cs_done = 1'bx; busy_done = 1'bx; sclk_done = 1'bx;
    limit = burst_cycles(nw, div) + 20;
    @(negedge clk);
    start = 1'b1; nwords = nw[9:0]; clk_div = div[7:0]; keep_cs = keep;
    tx_valid = valid; tx_data = word; SDDI = rx_pat[7];
    @(negedge clk);
    start = 1'b0;
    prev = 1'b0; low_run = 0; high_run = 0; acc = 8'h00;
    for (int it = 0; it < limit; it++) begin
      if (it > 0) @(negedge clk);
      if (it == 0) begin first_busy = busy; first_cs = SDCS; end
      if (SDCLK) begin
        if (!prev) begin
          exp_low = (rise_cnt == 0) ? div + 2 : ((rise_cnt % 8 == 0) ? div + 3 : div + 1);
          if (low_run != exp_low) bad_low++;
          low_run = 0;
          acc = {acc[6:0], SDDO};
          rise_cnt++;
          if (rise_cnt % 8 == 0) tx_bytes.push_back(acc);
          SDDI = rx_pat[7 - (rise_cnt % 8)];
        end
        high_run++;
      end else begin
        if (prev) begin
          if (high_run != div + 1) bad_high++;
          high_run = 0;
        end
        low_run++;
      end
      prev = SDCLK;
      if (tx_ready) n_txr++;
      if (rx_valid) begin rx_bytes.push_back(rx_data); rxv_iter = it; end
      if (extra && it == 5) start = 1'b1;
      if (extra && it == 6) start = 1'b0;
      if (done) begin
        done_seen = 1; done_iter = it; cs_done = SDCS; busy_done = busy; sclk_done = SDCLK;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int r, bad;
    logic p;
    n_rst = 1'b0; start = 1'b0; nwords = '0; clk_div = '0; keep_cs = 1'b0;
    tx_data = '0; tx_valid = 1'b0; SDDI = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sdcs", SDCS, 1); chk("rst_sdclk", SDCLK, 0); chk("rst_sddo", SDDO, 1);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0); chk("rst_crc", crc_out, 0); chk("rst_tx_ready", tx_ready, 0);
    n_rst = 1'b1;
    @(negedge clk);
    $display("reset released");

    // Single 0x40 word, half-period 2 cycles, SDDI stuck high
    burst(0, 1, 0, 1, 8'h40, 8'hFF, 0);
    $display("burst div=1 nw=0 tx=0x40: done_iter=%0d rx=%0d words", done_iter, rx_bytes.size());
    chk("b1_first_busy", first_busy, 1); chk("b1_first_cs", first_cs, 0);
    chk("b1_done_seen", done_seen, 1); chk("b1_done_iter", done_iter, burst_cycles(0, 1));
    chk("b1_tx_words", tx_bytes.size(), 1); chk("b1_sddo_byte", tx_bytes[0], 8'h40);
    chk("b1_bad_high", bad_high, 0); chk("b1_bad_low", bad_low, 0);
    chk("b1_rx_count", rx_bytes.size(), 1); chk("b1_rx_data", rx_bytes[0], 8'hFF);
    chk("b1_rxv_to_done", done_iter - rxv_iter, 1); chk("b1_tx_ready", n_txr, 1);
    chk("b1_cs_at_done", cs_done, 1); chk("b1_busy_at_done", busy_done, 0);
    chk("b1_sclk_at_done", sclk_done, 0);
    @(negedge clk);
    chk("b1_crc", crc_out, CRC_ON ? 32'(crc_ref(8'h40, 1)) : 32'h0);

    // Four fill words with keep_cs, then a releasing burst
    burst(3, 0, 1, 0, 8'h12, 8'h0F, 0);
    $display("burst div=0 nw=3 keep_cs fill: done_iter=%0d words=%0d", done_iter, tx_bytes.size());
    bad = 0;
    foreach (tx_bytes[i]) if (tx_bytes[i] !== 8'hFF) bad++;
    chk("b2_done_iter", done_iter, burst_cycles(3, 0)); chk("b2_tx_words", tx_bytes.size(), 4);
    chk("b2_fill_bytes", bad, 0); chk("b2_tx_ready", n_txr, 0); chk("b2_bad_low", bad_low, 0);
    chk("b2_rx_count", rx_bytes.size(), 4); chk("b2_rx_last", rx_bytes[3], 8'h0F);
    chk("b2_cs_at_done", cs_done, 0);
    repeat (4) @(negedge clk);
    chk("b2_cs_held", SDCS, 0); chk("b2_busy_idle", busy, 0);
    burst(0, 0, 0, 1, 8'h81, 8'hFF, 0);
    $display("burst releasing cs: done_iter=%0d cs_at_done=%0b", done_iter, cs_done);
    chk("b3_first_cs", first_cs, 0); chk("b3_cs_at_done", cs_done, 1);
    chk("b3_sddo_byte", tx_bytes[0], 8'h81);

    // Receive pattern 0xA5 at clk/2, two words to exercise the inter-word gap
    burst(1, 0, 0, 1, 8'h3C, 8'hA5, 0);
    $display("burst div=0 nw=1 rx=0xA5: rx words=%0d", rx_bytes.size());
    chk("b4_rx0", rx_bytes[0], 8'hA5); chk("b4_rx1", rx_bytes[1], 8'hA5);
    chk("b4_sddo_byte", tx_bytes[1], 8'h3C); chk("b4_bad_high", bad_high, 0);
    chk("b4_bad_low", bad_low, 0); chk("b4_tx_ready", n_txr, 2);

    // start while busy must be ignored
    burst(1, 2, 0, 1, 8'h99, 8'h5A, 1);
    $display("burst with extra start: done_iter=%0d words=%0d", done_iter, tx_bytes.size());
    chk("b5_done_iter", done_iter, burst_cycles(1, 2)); chk("b5_tx_words", tx_bytes.size(), 2);
    chk("b5_rx1", rx_bytes[1], 8'h5A); chk("b5_cs_at_done", cs_done, 1);
    repeat (3) @(negedge clk);
    chk("b5_no_restart", busy, 0);

    // Divider at all-ones
    burst(0, 255, 0, 1, 8'hE7, 8'h18, 0);
    $display("burst div=255: done_iter=%0d", done_iter);
    chk("b6_done_iter", done_iter, burst_cycles(0, 255)); chk("b6_bad_high", bad_high, 0);
    chk("b6_sddo_byte", tx_bytes[0], 8'hE7); chk("b6_rx", rx_bytes[0], 8'h18);

    // Reset in the middle of a bit
    @(negedge clk);
    start = 1'b1; nwords = 10'd1; clk_div = 8'd1; keep_cs = 1'b1; tx_valid = 1'b1;
    tx_data = 8'hC3; SDDI = 1'b1;
    @(negedge clk);
    start = 1'b0; r = 0; p = 1'b0;
    for (int i = 0; i < 300 && r < 4; i++) begin
      @(negedge clk);
      if (SDCLK && !p) r++;
      p = SDCLK;
    end
    chk("mr_reached_bit4", r, 4);
    #2 n_rst = 1'b0;
    #1;
    $display("reset asserted mid-bit");
    chk("mr_sdcs", SDCS, 1); chk("mr_sdclk", SDCLK, 0); chk("mr_sddo", SDDO, 1);
    chk("mr_busy", busy, 0); chk("mr_done", done, 0); chk("mr_tx_ready", tx_ready, 0);
    chk("mr_rx_valid", rx_valid, 0); chk("mr_rx_data", rx_data, 0); chk("mr_crc", crc_out, 0);
    @(negedge clk);
    n_rst = 1'b1;
    burst(0, 0, 0, 1, 8'h5A, 8'hC3, 0);
    $display("burst after reset: done_iter=%0d", done_iter);
    chk("ar_done_iter", done_iter, burst_cycles(0, 0)); chk("ar_sddo_byte", tx_bytes[0], 8'h5A);
    chk("ar_rx", rx_bytes[0], 8'hC3); chk("ar_cs_at_done", cs_done, 1);

    // 512 x 0xFF data block
    burst(511, 0, 0, 1, 8'hFF, 8'hFF, 0);
    $display("burst 512 x 0xFF: words=%0d crc=0x%04h", tx_bytes.size(), crc_out);
    chk("blk_tx_words", tx_bytes.size(), 512); chk("blk_tx_ready", n_txr, 512);
    chk("blk_crc_at_done", crc_out, CRC_ON ? 32'h7FA1 : 32'h0);
    repeat (3) @(negedge clk);
    chk("blk_crc_stable", crc_out, CRC_ON ? 32'h7FA1 : 32'h0);

    // Maximum burst length
    burst(1023, 0, 0, 0, 8'h00, 8'hFF, 0);
    $display("burst nwords=1023: words=%0d done_iter=%0d", tx_bytes.size(), done_iter);
    chk("max_tx_words", tx_bytes.size(), 1024); chk("max_rx_words", rx_bytes.size(), 1024);
    chk("max_done_iter", done_iter, burst_cycles(1023, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
